debounce_button_bank: RTL and testbench
=======================================

// Module: debounce_button_bank
// PURPOSE
//  Parametrised N-channel debouncer for raw pushbutton inputs; next generation of the single-button
//  debouncer. Per channel: 2-flop synchronizer, symmetric press AND release debounce, debounced level,
//  one-cycle press/release strobes, optional auto-repeat action strobe for held buttons (player movement).
//  Sits between board button pins and game control logic; all channels independent, one clock domain.
// PARAMETERS
//  N_BTN          4       number of independent button channels (>=1)
//  DB_CYCLES      200000  consecutive stable sync samples required to accept a press or a release (>=2)
//  REPEAT_EN      1       1: held button emits repeat strobes on act_pulse; 0: act_pulse == press_pulse
//  REPEAT_DELAY   50000000 cycles from level rise to first repeat strobe (>=1)
//  REPEAT_PERIOD  10000000 cycles between subsequent repeat strobes (>=1)
//  Counter widths are localparams via $clog2(max value + 1); no user width parameters.
// PORTS
//  clk            in   1      system clock; all logic rising-edge
//  reset_n        in   1      synchronous, active-low reset
//  btn_raw        in   N_BTN  asynchronous raw button inputs, 1 = pressed
//  db_level       out  N_BTN  debounced level, 1 = pressed
//  press_pulse    out  N_BTN  1-cycle strobe on accepted press (same cycle db_level rises)
//  release_pulse  out  N_BTN  1-cycle strobe on accepted release (same cycle db_level falls)
//  act_pulse      out  N_BTN  press_pulse OR repeat strobe
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): all outputs 0, synchronizers 0, all channels IDLE, counters 0.
//   Reset mid-debounce or mid-hold discards state; no release_pulse is emitted for a reset.
//  Sync: s = btn_raw after two flops; s used by FSM; raw-to-s latency 2 cycles.
//  Per-channel FSM (db_cnt, rpt_cnt per channel):
//   IDLE:     level 0. s=1 -> PRESS_WT, db_cnt=1.
//   PRESS_WT: level 0. s=0 -> IDLE, db_cnt=0. s=1 & db_cnt==DB_CYCLES-1 -> HELD, level 1,
//             press_pulse 1 for that cycle, rpt_cnt=0. else db_cnt++.
//   HELD:     level 1. s=0 -> RELEASE_WT, db_cnt=1, rpt_cnt holds. s=1 -> rpt_cnt++ (if REPEAT_EN).
//   RELEASE_WT: level 1. s=1 -> HELD, db_cnt=0, rpt_cnt resumes. s=0 & db_cnt==DB_CYCLES-1 -> IDLE,
//             level 0, release_pulse 1 that cycle, rpt_cnt=0. else db_cnt++.
//  Latency: stable raw press -> db_level/press_pulse registered DB_CYCLES+2 cycles after first
//   raw-high sample; release symmetric. Glitch shorter than DB_CYCLES samples: no output change.
//  Repeat (REPEAT_EN=1): rpt_cnt counts only in HELD. Repeat strobe when rpt_cnt reaches
//   REPEAT_DELAY (first), then every REPEAT_PERIOD after (rpt_cnt reloads to REPEAT_DELAY-REPEAT_PERIOD
//   or equivalent separate phase flag; no wrap of counter). Counter saturates, never overflows.
//  act_pulse = press_pulse | repeat strobe; never 2 cycles wide from one event; press and repeat never
//   coincide (first repeat >= 1 cycle after press).
//  Pulses are registered outputs, high exactly one cycle. press and release on one channel never same cycle.
//  Channels fully independent: simultaneous events on several channels each produce own strobes same cycle.
//  db_cnt width covers DB_CYCLES; saturation at DB_CYCLES-1 is unreachable outside WT states.
// TESTING (bench: N_BTN=4, DB_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
//  Reset: reset_n=0 with btn_raw=4'hF for 3 cycles -> all outputs 0; after release, level rises 10 cycles later.
//  Clean press ch0 held 40 cycles -> press_pulse[0]/act at cycle 10, act repeats at 30,35,40; other chans 0.
//  Bounce: ch1 high 5 cycles, low 2, high 20 -> no output for first burst; single press_pulse, no release.
//  Release bounce: ch1 held then low 3, high 2, low 12 -> no release on first dip; one release_pulse at end,
//   repeat strobes paused during dips.
//  Simultaneous: ch2 and ch3 pressed same cycle -> press_pulse[3:2]=2'b11 same cycle; release ch2 only ->
//   release_pulse=4'b0100, ch3 repeats continue.
//  REPEAT_EN=0 rebuild, ch0 held 100 cycles -> exactly one act_pulse; reset_n=0 mid-hold -> level 0, no release.

Source files
------------

// File: rtl/debounce_button_bank.sv
// N-channel pushbutton debouncer with press/release strobes and auto-repeat.
// Each channel: 2-flop synchronizer, symmetric debounce FSM, hold-repeat timer.
module debounce_button_bank #(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = 200000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] db_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] act_pulse
);

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                            : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WT   = 2'd1,
        HELD       = 2'd2,
        RELEASE_WT = 2'd3
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        state_t           r_state;
        logic [DB_W-1:0]  r_db_cnt;
        logic [RPT_W-1:0] r_rpt_cnt;
        logic             r_rpt_phase;
        logic             r_level;
        logic             r_press;
        logic             r_rel;
        logic             r_act;
        logic             w_s;
        logic [RPT_W-1:0] w_rpt_tgt;

        assign w_s = r_sync2[g];
        // First repeat waits the long delay, later ones the short period.
        assign w_rpt_tgt = r_rpt_phase ? RPT_NEXT : RPT_FIRST;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_state     <= IDLE;
                r_db_cnt    <= '0;
                r_rpt_cnt   <= '0;
                r_rpt_phase <= 1'b0;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_rel       <= 1'b0;
                r_act       <= 1'b0;
            end else begin
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_act   <= 1'b0;
                unique case (r_state)
                    IDLE: begin
                        if (w_s) begin
                            r_state  <= PRESS_WT;
                            r_db_cnt <= DB_W'(1);
                        end
                    end
                    PRESS_WT: begin
                        if (!w_s) begin
                            r_state  <= IDLE;
                            r_db_cnt <= '0;
                        end else if (r_db_cnt == DB_LAST) begin
                            r_state     <= HELD;
                            r_db_cnt    <= '0;
                            r_level     <= 1'b1;
                            r_press     <= 1'b1;
                            r_act       <= 1'b1;
                            r_rpt_cnt   <= '0;
                            r_rpt_phase <= 1'b0;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_W'(1);
                        end
                    end
                    HELD: begin
                        if (!w_s) begin
                            r_state  <= RELEASE_WT;
                            r_db_cnt <= DB_W'(1);
                        end else if (REPEAT_EN != 0) begin
                            if (r_rpt_cnt == w_rpt_tgt) begin
                                r_rpt_cnt   <= '0;
                                r_rpt_phase <= 1'b1;
                                r_act       <= 1'b1;
                            end else begin
                                r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                            end
                        end
                    end
                    RELEASE_WT: begin
                        if (w_s) begin
                            r_state  <= HELD;
                            r_db_cnt <= '0;
                        end else if (r_db_cnt == DB_LAST) begin
                            r_state     <= IDLE;
                            r_db_cnt    <= '0;
                            r_level     <= 1'b0;
                            r_rel       <= 1'b1;
                            r_rpt_cnt   <= '0;
                            r_rpt_phase <= 1'b0;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end

        assign db_level[g]      = r_level;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_rel;
        assign act_pulse[g]     = r_act;
    end

endmodule

// File: tb/tb_debounce_button_bank.sv
// Bench for debounce_button_bank: run-length reference model, directed
// scenarios, random bounce traffic, and a REPEAT_EN=0 twin instance.
module tb_debounce_button_bank;

    localparam int DB  = 8;
    localparam int DLY = 20;
    localparam int PER = 5;

    logic       clk;
    logic       reset_n;
    logic [3:0] btn_raw;
    logic [3:0] a_level, a_press, a_rel, a_act;
    logic [3:0] b_level, b_press, b_rel, b_act;

    int n_chk;
    int n_err;

    debounce_button_bank #(
        .N_BTN(4), .DB_CYCLES(DB), .REPEAT_EN(1),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .db_level(a_level), .press_pulse(a_press),
        .release_pulse(a_rel), .act_pulse(a_act)
    );

    debounce_button_bank #(
        .N_BTN(4), .DB_CYCLES(DB), .REPEAT_EN(0),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .db_level(b_level), .press_pulse(b_press),
        .release_pulse(b_rel), .act_pulse(b_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a level flips once the synchronized input has disagreed
    // with it for DB consecutive samples; repeats are keyed off the number
    // of undisturbed held samples since the press.
    logic [3:0] m_s1, m_s2;
    logic [3:0] exp_level, exp_press, exp_rel, exp_rpt;
    int         m_run  [4];
    int         m_tick [4];
    bit         m_s;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0;
            exp_level = '0; exp_press = '0; exp_rel = '0; exp_rpt = '0;
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0; m_tick[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_s = m_s2[i];
                exp_press[i] = 1'b0; exp_rel[i] = 1'b0; exp_rpt[i] = 1'b0;
                if (exp_level[i] && m_s && m_run[i] == 0) begin
                    m_tick[i]++;
                    if (m_tick[i] == DLY ||
                        (m_tick[i] > DLY && (m_tick[i] - DLY) % PER == 0))
                        exp_rpt[i] = 1'b1;
                end
                m_run[i] = (m_s != exp_level[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DB) begin
                    exp_level[i] = ~exp_level[i];
                    m_run[i]     = 0;
                    m_tick[i]    = 0;
                    exp_press[i] = exp_level[i];
                    exp_rel[i]   = ~exp_level[i];
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    logic [15:0] got_a, got_b, exp_a, exp_b;
    assign got_a = {a_level, a_press, a_rel, a_act};
    assign got_b = {b_level, b_press, b_rel, b_act};
    assign exp_a = {exp_level, exp_press, exp_rel, exp_press | exp_rpt};
    assign exp_b = {exp_level, exp_press, exp_rel, exp_press};

    task automatic settle();
        btn_raw = 4'h0;
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int rise;
        reset_n = 1'b0;
        btn_raw = 4'hF;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if (got_a !== 16'h0 || got_b !== 16'h0) begin
                n_err++;
                $display("FAIL reset_outputs cyc=%0d got_a=%h got_b=%h want=0",
                         c, got_a, got_b);
            end
        end
        reset_n = 1'b1;
        rise = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if (got_a !== exp_a || got_b !== exp_b) begin
                n_err++;
                $display("FAIL reset_model cyc=%0d a=%h/%h b=%h/%h",
                         c, got_a, exp_a, got_b, exp_b);
            end
            if (rise < 0 && a_level === 4'hF) rise = c;
        end
        n_chk++;
        if (rise != 10) begin
            n_err++;
            $display("FAIL reset_rise_latency got=%0d want=10", rise);
        end
    endtask

    task automatic test_clean_press();
        logic [63:0] ha, hb, want;
        logic [2:0]  other;
        ha = '0; hb = '0; other = '0;
        for (int c = 1; c <= 40; c++) begin
            btn_raw = 4'b0001;
            @(posedge clk); #1;
            n_chk++;
            if (got_a !== exp_a || got_b !== exp_b) begin
                n_err++;
                $display("FAIL clean_model cyc=%0d a=%h/%h b=%h/%h",
                         c, got_a, exp_a, got_b, exp_b);
            end
            if (a_act[0]) ha[c] = 1'b1;
            if (b_act[0]) hb[c] = 1'b1;
            other |= a_level[3:1] | a_press[3:1] | a_act[3:1];
        end
        want = '0;
        want[10] = 1'b1; want[30] = 1'b1; want[35] = 1'b1; want[40] = 1'b1;
        n_chk++;
        if (ha !== want) begin
            n_err++;
            $display("FAIL clean_act_cycles got=%h want=%h", ha, want);
        end
        want = '0;
        want[10] = 1'b1;
        n_chk++;
        if (hb !== want) begin
            n_err++;
            $display("FAIL clean_norpt_act got=%h want=%h", hb, want);
        end
        n_chk++;
        if (other !== 3'b000) begin
            n_err++;
            $display("FAIL clean_other_channels got=%b want=000", other);
        end
    endtask

    task automatic test_bounce();
        int npress, nrel, first;
        npress = 0; nrel = 0; first = -1;
        for (int c = 1; c <= 27; c++) begin
            btn_raw = (c <= 5 || c >= 8) ? 4'b0010 : 4'b0000;
            @(posedge clk); #1;
            n_chk++;
            if (got_a !== exp_a || got_b !== exp_b) begin
                n_err++;
                $display("FAIL bounce_model cyc=%0d a=%h/%h b=%h/%h",
                         c, got_a, exp_a, got_b, exp_b);
            end
            if (a_press[1]) begin
                npress++;
                if (first < 0) first = c;
            end
            if (a_rel[1]) nrel++;
        end
        n_chk++;
        if (npress != 1 || first != 17 || nrel != 0) begin
            n_err++;
            $display("FAIL bounce_press got=%0d@%0d rel=%0d want=1@17 rel=0",
                     npress, first, nrel);
        end
    endtask

    task automatic test_release_bounce();
        logic [63:0] ha, want;
        int nrel, at;
        ha = '0; nrel = 0; at = -1;
        for (int c = 1; c <= 47; c++) begin
            btn_raw = (c <= 30 || (c >= 34 && c <= 35)) ? 4'b0010 : 4'b0000;
            @(posedge clk); #1;
            n_chk++;
            if (got_a !== exp_a || got_b !== exp_b) begin
                n_err++;
                $display("FAIL relb_model cyc=%0d a=%h/%h b=%h/%h",
                         c, got_a, exp_a, got_b, exp_b);
            end
            if (a_act[1]) ha[c] = 1'b1;
            if (a_rel[1]) begin
                nrel++;
                at = c;
            end
        end
        want = '0;
        want[10] = 1'b1; want[30] = 1'b1;
        n_chk++;
        if (ha !== want) begin
            n_err++;
            $display("FAIL relb_act_cycles got=%h want=%h", ha, want);
        end
        n_chk++;
        if (nrel != 1 || at != 45) begin
            n_err++;
            $display("FAIL relb_release got=%0d@%0d want=1@45", nrel, at);
        end
    endtask

    task automatic test_simultaneous();
        int nrpt;
        nrpt = 0;
        for (int c = 1; c <= 60; c++) begin
            btn_raw = (c <= 30) ? 4'b1100 : 4'b1000;
            @(posedge clk); #1;
            n_chk++;
            if (got_a !== exp_a || got_b !== exp_b) begin
                n_err++;
                $display("FAIL simul_model cyc=%0d a=%h/%h b=%h/%h",
                         c, got_a, exp_a, got_b, exp_b);
            end
            if (c == 10) begin
                n_chk++;
                if (a_press !== 4'b1100 || b_press !== 4'b1100) begin
                    n_err++;
                    $display("FAIL simul_press got=%b/%b want=1100",
                             a_press, b_press);
                end
            end
            if (c == 40) begin
                n_chk++;
                if (a_rel !== 4'b0100) begin
                    n_err++;
                    $display("FAIL simul_release got=%b want=0100", a_rel);
                end
            end
            if (c > 40 && a_act[3]) nrpt++;
        end
        n_chk++;
        if (nrpt != 4) begin
            n_err++;
            $display("FAIL simul_ch3_repeats got=%0d want=4", nrpt);
        end
    endtask

    task automatic test_random();
        int left [4];
        logic [3:0] cur;
        cur = '0;
        for (int i = 0; i < 4; i++) left[i] = 0;
        for (int c = 1; c <= 1200; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (left[i] == 0) begin
                    cur[i]  = ~cur[i];
                    left[i] = ($urandom_range(0, 3) == 0) ?
                              $urandom_range(20, 60) : $urandom_range(1, 12);
                end
                left[i]--;
            end
            btn_raw = cur;
            @(posedge clk); #1;
            n_chk++;
            if (got_a !== exp_a || got_b !== exp_b) begin
                n_err++;
                $display("FAIL random_model cyc=%0d raw=%b a=%h/%h b=%h/%h",
                         c, cur, got_a, exp_a, got_b, exp_b);
            end
        end
    endtask

    task automatic test_norepeat_reset();
        int na, nb;
        logic [3:0] seen;
        na = 0; nb = 0; seen = '0;
        for (int c = 1; c <= 100; c++) begin
            btn_raw = 4'b0001;
            @(posedge clk); #1;
            n_chk++;
            if (got_a !== exp_a || got_b !== exp_b) begin
                n_err++;
                $display("FAIL hold_model cyc=%0d a=%h/%h b=%h/%h",
                         c, got_a, exp_a, got_b, exp_b);
            end
            if (a_act[0]) na++;
            if (b_act[0]) nb++;
        end
        n_chk++;
        if (nb != 1 || na != 16) begin
            n_err++;
            $display("FAIL hold_act_count got_b=%0d got_a=%0d want=1/16",
                     nb, na);
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (a_level !== 4'h0 || b_level !== 4'h0 ||
            a_rel !== 4'h0 || b_rel !== 4'h0) begin
            n_err++;
            $display("FAIL midhold_reset lvl=%b/%b rel=%b/%b want=0",
                     a_level, b_level, a_rel, b_rel);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        btn_raw = 4'h0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            seen |= a_rel | b_rel | a_level | b_level;
        end
        n_chk++;
        if (seen !== 4'h0) begin
            n_err++;
            $display("FAIL after_reset_quiet got=%b want=0000", seen);
        end
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        btn_raw = 4'h0;
        test_reset();
        settle();
        test_clean_press();
        settle();
        test_bounce();
        settle();
        test_release_bounce();
        settle();
        test_simultaneous();
        settle();
        test_random();
        settle();
        test_norepeat_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
